adder_ring_freq_meter: RTL and testbench

//  Downstream of the instrumented adder: measures the ring oscillator formed through the adder chain (chain_out).

---
 rtl/adder_ring_freq_meter_pkg.sv | 13 +
 rtl/adder_ring_freq_meter_sync.sv | 30 +++
 rtl/adder_ring_freq_meter.sv | 150 +++++++++++++++
 tb/tb_adder_ring_freq_meter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_ring_freq_meter_pkg.sv
// Shared FSM state encoding and default synchroniser depth for the ring frequency meter.
package adder_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } meter_state_e;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/adder_ring_freq_meter_sync.sv
// ring_sync_edge: brings the asynchronous ring output into the wb_clk_i domain and flags
// rising edges of the synchronised level.
module ring_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ring,
  output logic o_sync,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchroniser chain plus one-cycle-delayed copy for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ring};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/adder_ring_freq_meter.sv
// Ring oscillator frequency meter: counts ring edges over a window of clocks.
// Build option FREQ_METER_SATURATE_EN: counter saturates instead of wrapping.
module adder_ring_freq_meter
  import adder_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int WIN_W       = 32,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_cycles,
  input  logic             ring_in,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  meter_state_e     r_state;
  logic [WIN_W-1:0] r_win_cnt;
  logic [ARM_W-1:0] r_arm_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_sync;
  logic             w_edge;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;

  ring_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_ring (ring_in),
    .o_sync (w_sync),
    .o_edge (w_edge)
  );

  assign w_cnt_en = w_edge & w_sync & (r_state == ST_MEASURE);

  // Next edge-counter value; overflow is sticky once a carry out of the top bit is seen
  always_comb begin
    w_cnt_next = r_cnt;
    w_ovf_next = r_ovf;
    if (w_cnt_en) begin
      if (&r_cnt) begin
`ifdef FREQ_METER_SATURATE_EN
        w_cnt_next = r_cnt;
`else
        w_cnt_next = {CNT_W{1'b0}};
`endif
        w_ovf_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_ovf_next = r_ovf;
      end
    end else begin
      w_cnt_next = r_cnt;
      w_ovf_next = r_ovf;
    end
  end

  // Measurement FSM with window down-counter and registered outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_win_cnt  <= {WIN_W{1'b0}};
      r_arm_cnt  <= {ARM_W{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_ovf      <= 1'b0;
      ring_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= {CNT_W{1'b0}};
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (window_cycles != {WIN_W{1'b0}}) begin
              r_win_cnt <= window_cycles;
              r_arm_cnt <= {ARM_W{1'b0}};
              r_cnt     <= {CNT_W{1'b0}};
              r_ovf     <= 1'b0;
              ring_en   <= 1'b1;
              busy      <= 1'b1;
              r_state   <= ST_ARM;
            end else begin
              // Zero-length window completes immediately without running the ring
              edge_count <= {CNT_W{1'b0}};
              overflow   <= 1'b0;
              done       <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
        end
        ST_ARM: begin
          if (abort) begin
            ring_en <= 1'b0;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_arm_cnt == ARM_W'(SYNC_STAGES - 1)) begin
            r_state <= ST_MEASURE;
          end else begin
            r_arm_cnt <= r_arm_cnt + {{(ARM_W-1){1'b0}}, 1'b1};
          end
        end
        ST_MEASURE: begin
          if (abort) begin
            ring_en <= 1'b0;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (r_win_cnt == WIN_W'(1)) begin
              // Last window cycle: its edge is included in the published result
              ring_en    <= 1'b0;
              busy       <= 1'b0;
              edge_count <= w_cnt_next;
              overflow   <= w_ovf_next;
              done       <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_win_cnt <= r_win_cnt - WIN_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          ring_en <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_ring_freq_meter.sv
// Self-checking bench: table-driven periodic rings, randomized rings against a sample-history
// model, plus abort / reset / re-start sequences. Also checks a 4-bit counter variant.
module tb_adder_ring_freq_meter;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] window = 32'd0;
  logic        ring_in = 1'b0;

  logic        ring_en, busy, done, overflow;
  logic [31:0] edge_count;
  logic        s_ring_en, s_busy, s_done, s_overflow;
  logic [3:0]  s_edge_count;

  int n_cmp = 0;
  int n_err = 0;

  adder_ring_freq_meter #(.CNT_W(32), .WIN_W(32), .SYNC_STAGES(S)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .window_cycles(window), .ring_in(ring_in), .ring_en(ring_en), .busy(busy),
    .done(done), .edge_count(edge_count), .overflow(overflow)
  );

  adder_ring_freq_meter #(.CNT_W(4), .WIN_W(32), .SYNC_STAGES(S)) dut_small (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .window_cycles(window), .ring_in(ring_in), .ring_en(s_ring_en), .busy(s_busy),
    .done(s_done), .edge_count(s_edge_count), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  // Ring stimulus: 0 = constant level, 1 = periodic, 2 = random bit per clock
  int ring_mode = 0;
  int ring_per  = 8;
  int ring_ph   = 0;
  bit ring_lvl  = 1'b0;

  always @(negedge clk) begin
    if (ring_mode == 0) ring_in <= ring_lvl;
    else if (ring_mode == 1) begin
      ring_ph <= (ring_ph + 1) % ring_per;
      ring_in <= (((ring_ph + 1) % ring_per) >= (ring_per / 2));
    end else ring_in <= 1'($urandom % 2);
  end

  // History of ring_in as seen at each rising clock edge
  bit hist [0:32767];
  int cyc = 0;
  always @(posedge clk) begin
    hist[cyc] <= ring_in;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rising transitions of ring_in over the W clock edges following the start edge
  function automatic int model_edges(input int t, input int w);
    int n = 0;
    for (int j = t + 1; j <= t + w; j++)
      if (hist[j] && !hist[j-1]) n++;
    return n;
  endfunction

  function automatic int small_cnt(input int n);
`ifdef FREQ_METER_SATURATE_EN
    return (n > 15) ? 15 : n;
`else
    return n % 16;
`endif
  endfunction

  int t_s, lat_s, busy_s, done_s, en0_s, en_any_s;

  task automatic run_meas(input int win);
    @(negedge clk);
    window = 32'(win);
    start  = 1'b1;
    @(posedge clk);
    t_s = cyc;
    #1 start = 1'b0;
    lat_s = -1; busy_s = 0; done_s = 0; en0_s = ring_en; en_any_s = 0;
    for (int k = 0; k < win + S + 6; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) busy_s++;
      if (ring_en) en_any_s = 1;
      if (done) begin
        done_s++;
        if (lat_s < 0) lat_s = k;
      end
    end
  endtask

  task automatic check_run(input string tag, input int win, input int exp_n);
    int n;
    n = (exp_n >= 0) ? exp_n : model_edges(t_s, win);
    chk({tag, "_count"}, edge_count, n);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_latency"}, lat_s, (win == 0) ? 0 : S + win);
    chk({tag, "_busy_cycles"}, busy_s, (win == 0) ? 0 : S + win);
    chk({tag, "_done_pulses"}, done_s, 1);
    chk({tag, "_ring_en_first"}, en0_s, (win != 0) ? 1 : 0);
    chk({tag, "_ring_en_any"}, en_any_s, (win != 0) ? 1 : 0);
    chk({tag, "_small_count"}, s_edge_count, small_cnt(n));
    chk({tag, "_small_ovf"}, s_overflow, (n > 15) ? 1 : 0);
  endtask

  typedef struct {
    int per;
    int win;
    int exp_n;
  } vec_t;

  vec_t tbl [7];
  int   dn;

  initial begin
    tbl[0] = '{per: 8,  win: 80, exp_n: 10};
    tbl[1] = '{per: 4,  win: 80, exp_n: 20};
    tbl[2] = '{per: 4,  win: 40, exp_n: 10};
    tbl[3] = '{per: 10, win: 50, exp_n: 5};
    tbl[4] = '{per: 3,  win: 30, exp_n: 10};
    tbl[5] = '{per: 16, win: 32, exp_n: 2};
    tbl[6] = '{per: 2,  win: 20, exp_n: 10};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ring_en, busy, done, overflow, edge_count}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);

    // Table of periodic rings
    ring_mode = 1;
    foreach (tbl[i]) begin
      ring_per = tbl[i].per;
      repeat (3) @(posedge clk);
      run_meas(tbl[i].win);
      check_run($sformatf("tbl%0d", i), tbl[i].win, tbl[i].exp_n);
    end

    // Zero window: immediate done, ring never enabled
    run_meas(0);
    check_run("win0", 0, 0);

    // Randomized rings against the history model
    ring_mode = 2;
    for (int r = 0; r < 6; r++) begin
      run_meas($urandom_range(60, 1));
      check_run($sformatf("rnd%0d", r), int'(window), -1);
    end

    // Abort mid-MEASURE keeps the previous result
    ring_mode = 1; ring_per = 8;
    run_meas(80);
    check_run("pre_abort", 80, 10);
    @(negedge clk); window = 32'd80; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_ring_en", ring_en, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk) abort = 1'b0;
    dn = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_count_kept", edge_count, 10);

    // Start and abort together in IDLE: nothing starts
    @(negedge clk); start = 1'b1; abort = 1'b1; window = 32'd10;
    @(posedge clk); #1;
    chk("start_abort_idle", {ring_en, busy}, 0);
    @(negedge clk); start = 1'b0; abort = 1'b0;

    // Asynchronous reset in the middle of a measurement
    @(negedge clk); window = 32'd80; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {ring_en, busy, done, overflow, edge_count}, 0);
    chk("async_rst_small", {s_ring_en, s_busy, s_done, s_overflow, s_edge_count}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    run_meas(40);
    check_run("post_rst", 40, 5);

    // Re-start while busy is ignored; ring held high gives zero edges
    ring_mode = 0; ring_lvl = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); window = 32'd80; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    window = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dn = 0; lat_s = -1;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        if (lat_s < 0) lat_s = k;
      end
    end
    chk("restart_done_pulses", dn, 1);
    chk("restart_latency", lat_s, S + 80 - 22);
    chk("restart_count", edge_count, 0);
    chk("restart_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
